xor_if_driver: RTL and testbench

//  Upstream command sequencer for the XOR FIFO dut. Accepts (a,b) operand pairs on a valid/ready stream.

---
 rtl/xor_if_pkg.sv | 10 +
 rtl/xor_if_poller.sv | 24 ++
 rtl/xor_if_driver.sv | 96 +++++++++
 tb/tb_xor_if_driver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_if_pkg.sv
// xor_if_pkg: address map and FSM state encoding shared by the XOR FIFO driver files
package xor_if_pkg;
  localparam logic [2:0] ADDR_A_STAT = 3'd0;
  localparam logic [2:0] ADDR_B_STAT = 3'd1;
  localparam logic [2:0] ADDR_Y_STAT = 3'd2;
  localparam logic [2:0] ADDR_Y_DATA = 3'd3;
  localparam logic [2:0] ADDR_A_DATA = 3'd4;
  localparam logic [2:0] ADDR_B_DATA = 3'd5;
  typedef enum logic [3:0] {IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, PUSH, ERROR} drv_state_t;
endpackage

// File: rtl/xor_if_poller.sv
// xor_if_poller: one status-poll read with consecutive not-ready counter and timeout detect
module xor_if_poller #(
  parameter int POLL_LIMIT = 255
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic active,
  input  logic read_rdy,
  input  logic read_data,
  output logic read_en,
  output logic ok,
  output logic timeout
);
  localparam int W = POLL_LIMIT > 1 ? $clog2(POLL_LIMIT) : 1;
  logic [W-1:0] cnt;
  assign read_en = active && read_rdy;
  assign ok = read_en && read_data;
  assign timeout = read_en && !read_data && cnt == W'(POLL_LIMIT - 1);
  // Leaving any poll state clears the count, so every poll state starts from zero
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) cnt <= '0;
    else if (!active || ok) cnt <= '0;
    else if (read_en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/xor_if_driver.sv
// xor_if_driver: sequences operand pairs through the XOR FIFO dut method ports.
// Define XOR_DRV_CHECK_EN to add the sticky err_mismatch result check.
module xor_if_driver
  import xor_if_pkg::*;
#(
  parameter int POLL_LIMIT = 255,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  output logic             in_ready,
  output logic             out_valid,
  output logic             out_y,
  input  logic             out_ready,
  output logic [2:0]       write_address,
  output logic             write_data,
  output logic             write_en,
  input  logic             write_rdy,
  output logic [2:0]       read_address,
  output logic             read_en,
  input  logic             read_data,
  input  logic             read_rdy,
  output logic [CNT_W-1:0] txn_count,
`ifdef XOR_DRV_CHECK_EN
  output logic             err_timeout,
  output logic             err_mismatch
`else
  output logic             err_timeout
`endif
);
  drv_state_t state, nxt;
  logic a, b, poll_st, poll_en, poll_ok, poll_to, rd_y_fire;
  assign poll_st = state inside {POLL_A, POLL_B, POLL_Y};
  assign rd_y_fire = state == RD_Y && read_rdy;
  assign in_ready = RST_N && state == IDLE;
  assign out_valid = state == PUSH;
  assign read_en = poll_en || rd_y_fire;
  assign write_en = (state == WR_A || state == WR_B) && write_rdy;
  assign write_data = (state == WR_A && a) || (state == WR_B && b);
  assign write_address = state == WR_A ? ADDR_A_DATA : state == WR_B ? ADDR_B_DATA : 3'd0;
  assign read_address = state == POLL_A ? ADDR_A_STAT :
                        state == POLL_B ? ADDR_B_STAT :
                        state == POLL_Y ? ADDR_Y_STAT :
                        state == RD_Y   ? ADDR_Y_DATA : 3'd0;
  xor_if_poller #(.POLL_LIMIT(POLL_LIMIT)) u_poll (
    .CLK(CLK),
    .RST_N(RST_N),
    .active(poll_st),
    .read_rdy(read_rdy),
    .read_data(read_data),
    .read_en(poll_en),
    .ok(poll_ok),
    .timeout(poll_to)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = POLL_A;
      POLL_A:  nxt = poll_to ? ERROR : poll_ok ? WR_A : POLL_A;
      WR_A:    if (write_en) nxt = POLL_B;
      POLL_B:  nxt = poll_to ? ERROR : poll_ok ? WR_B : POLL_B;
      WR_B:    if (write_en) nxt = POLL_Y;
      POLL_Y:  nxt = poll_to ? ERROR : poll_ok ? RD_Y : POLL_Y;
      RD_Y:    if (rd_y_fire) nxt = PUSH;
      PUSH:    if (out_ready) nxt = IDLE;
      default: nxt = state;
    endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      a <= 1'b0;
      b <= 1'b0;
      out_y <= 1'b0;
      txn_count <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        a <= in_a;
        b <= in_b;
      end
      if (rd_y_fire) out_y <= read_data;
      if (out_valid && out_ready) txn_count <= txn_count + 1'b1;
      if (poll_to) err_timeout <= 1'b1;
    end
`ifdef XOR_DRV_CHECK_EN
  // Popped value is still delivered as-is; the flag only records disagreement
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) err_mismatch <= 1'b0;
    else if (rd_y_fire && read_data != (a ^ b)) err_mismatch <= 1'b1;
`endif
endmodule

// File: tb/tb_xor_if_driver.sv
// tb_xor_if_driver: scoreboard bench for xor_if_driver against a behavioural dut method model
module tb_xor_if_driver;
  localparam int CNT_W = 16;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic in_valid = 1'b0, in_a = 1'b0, in_b = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, out_y;
  logic [2:0] write_address, read_address;
  logic write_data, write_en, write_rdy, read_en, read_data, read_rdy;
  logic [CNT_W-1:0] txn_count;
  logic err_timeout;
`ifdef XOR_DRV_CHECK_EN
  logic err_mismatch;
`endif
  int checks = 0, errors = 0, cyc = 0;
  int rd0 = 0, rd2 = 0, a_zero_until = 0;
  logic y_stuck = 1'b0, force_en = 1'b0, force_y = 1'b0, block_b = 1'b0, rd_toggle = 1'b0;
  logic ma = 1'b0, mb = 1'b0, seen = 1'b0;
  typedef struct {logic y; int at;} exp_t;
  typedef struct {logic [2:0] addr; logic data;} wr_t;
  exp_t exp_q[$];
  wr_t exp_w[$];
  exp_t e;
  wr_t w;

  xor_if_driver #(.POLL_LIMIT(4), .CNT_W(CNT_W)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .in_valid(in_valid),
    .in_a(in_a),
    .in_b(in_b),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_y(out_y),
    .out_ready(out_ready),
    .write_address(write_address),
    .write_data(write_data),
    .write_en(write_en),
    .write_rdy(write_rdy),
    .read_address(read_address),
    .read_en(read_en),
    .read_data(read_data),
    .read_rdy(read_rdy),
    .txn_count(txn_count),
    .err_timeout(err_timeout)
`ifdef XOR_DRV_CHECK_EN
    , .err_mismatch(err_mismatch)
`endif
  );

  always #5 CLK = ~CLK;

  // dut method model: status answers are steered by the stimulus knobs
  assign write_rdy = !(block_b && write_address == 3'd5);
  assign read_rdy = rd_toggle ? cyc[0] : 1'b1;
  always_comb
    case (read_address)
      3'd0:    read_data = rd0 >= a_zero_until;
      3'd1:    read_data = 1'b1;
      3'd2:    read_data = !y_stuck;
      3'd3:    read_data = force_en ? force_y : ma ^ mb;
      default: read_data = 1'b0;
    endcase
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (write_en && write_rdy) begin
      if (write_address == 3'd5) mb <= write_data;
      else ma <= write_data;
    end
    if (read_en && read_rdy && read_address == 3'd0) rd0 <= rd0 + 1;
    if (read_en && read_rdy && read_address == 3'd2) rd2 <= rd2 + 1;
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK)
    if (!RST_N) begin
      exp_q.delete();
      exp_w.delete();
      seen = 1'b0;
    end else begin
      if (write_en) begin
        check("write_en_rdy", write_rdy, 1);
        if (exp_w.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL write_unexpected: addr %0d data %0d with nothing expected", write_address, write_data);
        end else begin
          w = exp_w.pop_front();
          check("write_addr", write_address, w.addr);
          check("write_data", write_data, w.data);
        end
      end
      if (read_en) check("read_en_rdy", read_rdy, 1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: out_y=%0d with nothing expected", out_y);
        end else begin
          if (!seen && exp_q[0].at >= 0) check("latency_cycle", cyc, exp_q[0].at);
          seen = 1'b1;
          if (out_ready) begin
            e = exp_q.pop_front();
            check("out_y", out_y, e.y);
            seen = 1'b0;
          end
        end
      end
    end

  task automatic send(input logic a, input logic b, input int lat, input logic y);
    int n = 0;
    @(posedge CLK);
    #1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge CLK);
    while (!in_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_accept: in_ready got 0 required 1 after %0d cycles", n);
    end else begin
      exp_q.push_back('{y: y, at: lat < 0 ? -1 : cyc + lat});
      exp_w.push_back('{addr: 3'd4, data: a});
      exp_w.push_back('{addr: 3'd5, data: b});
    end
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done: result pending got %0d required 0 after %0d cycles", exp_q.size(), n);
    end
    @(negedge CLK);
  endtask

  initial begin
    int base, t0, n;
    @(negedge CLK);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_y", out_y, 0);
    check("rst_write_en", write_en, 0);
    check("rst_read_en", read_en, 0);
    check("rst_write_addr", write_address, 0);
    check("rst_read_addr", read_address, 0);
    check("rst_txn_count", txn_count, 0);
    check("rst_err_timeout", err_timeout, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("idle_in_ready", in_ready, 1);
    send(1'b1, 1'b0, 7, 1'b1);
    wait_done();
    check("txn_count_1", txn_count, 1);
    base = rd0;
    a_zero_until = rd0 + 3;
    send(1'b0, 1'b1, 10, 1'b1);
    wait_done();
    check("a_status_reads", rd0 - base, 4);
    check("no_timeout", err_timeout, 0);
    rd_toggle = 1'b1;
    send(1'b1, 1'b1, -1, 1'b0);
    wait_done();
    rd_toggle = 1'b0;
    check("txn_count_3", txn_count, 3);
    out_ready = 1'b0;
    t0 = int'(txn_count);
    send(1'b0, 1'b0, 7, 1'b0);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    repeat (10) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_y", out_y, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_txn_count", txn_count, t0);
      @(negedge CLK);
    end
    @(posedge CLK);
    #1 out_ready = 1'b1;
    wait_done();
    check("bp_txn_count_after", txn_count, t0 + 1);
    block_b = 1'b1;
    send(1'b1, 1'b0, -1, 1'b1);
    n = 0;
    @(negedge CLK);
    while (write_address != 3'd5 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("wr_b_reached", write_address, 5);
    check("wr_b_stall_en", write_en, 0);
    RST_N = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_write_addr", write_address, 0);
    check("mid_rst_write_en", write_en, 0);
    check("mid_rst_read_en", read_en, 0);
    check("mid_rst_txn_count", txn_count, 0);
    block_b = 1'b0;
    @(negedge CLK);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_y", out_y, 0);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("mid_rst_release_in_ready", in_ready, 1);
`ifdef XOR_DRV_CHECK_EN
    send(1'b1, 1'b1, 7, 1'b0);
    wait_done();
    check("mismatch_clean", err_mismatch, 0);
    force_en = 1'b1;
    force_y = 1'b1;
    send(1'b1, 1'b1, 7, 1'b1);
    wait_done();
    check("mismatch_set", err_mismatch, 1);
    force_en = 1'b0;
`endif
    y_stuck = 1'b1;
    base = rd2;
    send(1'b0, 1'b1, -1, 1'b1);
    n = 0;
    while (!err_timeout && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("timeout_set", err_timeout, 1);
    check("y_status_reads", rd2 - base, 4);
    in_valid = 1'b1;
    repeat (3) begin
      check("error_in_ready", in_ready, 0);
      check("error_read_en", read_en, 0);
      check("error_write_en", write_en, 0);
      @(negedge CLK);
    end
    in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
